// File: rtl/tile_attr_buffer_if.sv
// tile_attr_buffer_if: bus-side write and read channels of the tile buffer
interface tile_attr_buffer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int BUS_WIDTH  = 32
);
    logic                    wr_en_i;
    logic                    wr_ready_o;
    logic [ADDR_WIDTH-1:0]   w_addr_i;
    logic [BUS_WIDTH/8-1:0]  w_strb_i;
    logic [BUS_WIDTH-1:0]    din_i;
    logic                    r_req_i;
    logic [ADDR_WIDTH-1:0]   r_addr_i;
    logic [BUS_WIDTH-1:0]    r_data_o;
    logic                    r_valid_o;
    modport master (
        output wr_en_i, w_addr_i, w_strb_i, din_i, r_req_i, r_addr_i,
        input  wr_ready_o, r_data_o, r_valid_o
    );
    modport slave (
        input  wr_en_i, w_addr_i, w_strb_i, din_i, r_req_i, r_addr_i,
        output wr_ready_o, r_data_o, r_valid_o
    );
endinterface

// File: rtl/tile_attr_buffer.sv
// tile_attr_buffer: text-mode tile memory with bus/display access, fill engine and row-pointer scroll
module tile_attr_buffer #(
    parameter int H_TILES    = 80,
    parameter int V_TILES    = 30,
    parameter int NUM_TILES  = H_TILES * V_TILES,
    parameter int CHAR_WIDTH = 7,
    parameter int ATTR_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int LANES      = BUS_WIDTH / 16,
    parameter int ADDR_WIDTH = $clog2(NUM_TILES),
    parameter int COL_WIDTH  = $clog2(H_TILES),
    parameter int ROW_WIDTH  = $clog2(V_TILES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tile_attr_buffer_if.slave     bus,
    input  logic [COL_WIDTH-1:0]  col_r_i,
    input  logic [ROW_WIDTH-1:0]  row_r_i,
    output logic [CHAR_WIDTH-1:0] dout_char_o,
    output logic [ATTR_WIDTH-1:0] dout_attr_o,
    input  logic                  clear_i,
    input  logic                  scroll_i,
    input  logic [CHAR_WIDTH-1:0] fill_char_i,
    input  logic [ATTR_WIDTH-1:0] fill_attr_i,
    output logic                  busy_o,
    output logic [ROW_WIDTH-1:0]  scroll_row_o
);
    localparam int TW = CHAR_WIDTH + ATTR_WIDTH;
    localparam int AW = ADDR_WIDTH + 2;
    localparam logic [AW-1:0]         NT  = AW'(NUM_TILES);
    localparam logic [AW-1:0]         HT  = AW'(H_TILES);
    localparam logic [AW-1:0]         HT1 = AW'(H_TILES - 1);
    localparam logic [ROW_WIDTH:0]    VT  = (ROW_WIDTH + 1)'(V_TILES);
    localparam logic [COL_WIDTH:0]    HC  = (COL_WIDTH + 1)'(H_TILES);
    localparam logic [ROW_WIDTH-1:0]  VL  = ROW_WIDTH'(V_TILES - 1);
    typedef enum logic [1:0] {IDLE, FILL_ALL, FILL_ROW} state_t;
    state_t                r_state, w_next;
    logic [TW-1:0]         r_mem [NUM_TILES];
    logic [ROW_WIDTH-1:0]  r_scroll_row;
    logic [ADDR_WIDTH-1:0] r_cnt, r_last;
    logic [TW-1:0]         r_fill;
    logic [AW-1:0]         w_off;
    logic                  w_start_clr, w_start_scr, w_fill_we, w_wr_fire, w_disp_ok;
    logic [AW-1:0]         w_wl [LANES];
    logic [AW-1:0]         w_rl [LANES];
    logic [ADDR_WIDTH-1:0] w_wp [LANES];
    logic [ADDR_WIDTH-1:0] w_rp [LANES];
    logic [LANES-1:0]      w_wok, w_rok;
    logic [BUS_WIDTH-1:0]  w_rdata;
    logic [ROW_WIDTH:0]    w_prow_s, w_prow;
    logic [ADDR_WIDTH-1:0] w_dp;

    // Logical-to-physical: the screen top lives at physical row scroll_row.
    function automatic logic [ADDR_WIDTH-1:0] to_phys(input logic [AW-1:0] lg, input logic [AW-1:0] off);
        logic [AW-1:0] s;
        s = lg + off;
        return ADDR_WIDTH'((s >= NT) ? s - NT : s);
    endfunction

    assign w_off           = AW'(r_scroll_row) * HT;
    assign busy_o          = r_state != IDLE;
    assign bus.wr_ready_o  = !busy_o;
    assign scroll_row_o    = r_scroll_row;
    assign w_wr_fire       = bus.wr_en_i && !busy_o;
    assign w_fill_we       = busy_o && !rst_i;
    assign w_start_clr     = !busy_o && clear_i;
    assign w_start_scr     = !busy_o && scroll_i && !clear_i;
    assign w_prow_s        = {1'b0, row_r_i} + {1'b0, r_scroll_row};
    assign w_prow          = (w_prow_s >= VT) ? w_prow_s - VT : w_prow_s;
    assign w_dp            = ADDR_WIDTH'(w_prow) * ADDR_WIDTH'(H_TILES) + ADDR_WIDTH'(col_r_i);
    assign w_disp_ok       = ({1'b0, col_r_i} < HC) && ({1'b0, row_r_i} < VT);

    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < LANES; k++) begin
            w_wl[k]  = AW'(bus.w_addr_i) + AW'(k);
            w_rl[k]  = AW'(bus.r_addr_i) + AW'(k);
            w_wok[k] = w_wr_fire && (&bus.w_strb_i[2*k +: 2]) && (w_wl[k] < NT);
            w_rok[k] = w_rl[k] < NT;
            w_wp[k]  = to_phys(w_wl[k], w_off);
            w_rp[k]  = to_phys(w_rl[k], w_off);
            if (w_rok[k]) begin
                w_rdata[16*k +: CHAR_WIDTH]   = r_mem[w_rp[k]][CHAR_WIDTH-1:0];
                w_rdata[16*k+8 +: ATTR_WIDTH] = r_mem[w_rp[k]][TW-1:CHAR_WIDTH];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = w_start_clr ? FILL_ALL : w_start_scr ? FILL_ROW : IDLE;
        else if (r_cnt == r_last)
            w_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_scroll_row  <= '0;
            r_cnt         <= '0;
            r_last        <= '0;
            r_fill        <= '0;
            bus.r_valid_o <= 1'b0;
            bus.r_data_o  <= '0;
            dout_char_o   <= '0;
            dout_attr_o   <= '0;
        end else begin
            r_state       <= w_next;
            bus.r_valid_o <= bus.r_req_i;
            if (bus.r_req_i)
                bus.r_data_o <= w_rdata;
            {dout_attr_o, dout_char_o} <= w_disp_ok ? r_mem[w_dp] : '0;
            if (w_start_clr) begin
                r_cnt  <= '0;
                r_last <= ADDR_WIDTH'(NUM_TILES - 1);
                r_fill <= {fill_attr_i, fill_char_i};
            end else if (w_start_scr) begin
                r_cnt        <= w_off[ADDR_WIDTH-1:0];
                r_last       <= ADDR_WIDTH'(w_off + HT1);
                r_fill       <= {fill_attr_i, fill_char_i};
                r_scroll_row <= (r_scroll_row == VL) ? '0 : r_scroll_row + 1'b1;
            end else if (busy_o) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Memory is never reset; the fill engine and bus writes are mutually exclusive via wr_ready.
    always_ff @(posedge clk_i) begin
        if (w_fill_we)
            r_mem[r_cnt] <= r_fill;
        for (int k = 0; k < LANES; k++)
            if (w_wok[k])
                r_mem[w_wp[k]] <= {bus.din_i[16*k+8 +: ATTR_WIDTH], bus.din_i[16*k +: CHAR_WIDTH]};
    end
endmodule

// File: tb/tb_tile_attr_buffer.sv
// tb_tile_attr_buffer: directed scoreboard bench for tile_attr_buffer
module tb_tile_attr_buffer;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    tile_attr_buffer_if bus ();
    logic [6:0] col_r_i = '0;
    logic [4:0] row_r_i = '0;
    logic [6:0] dout_char_o;
    logic [7:0] dout_attr_o;
    logic       clear_i = 1'b0;
    logic       scroll_i = 1'b0;
    logic [6:0] fill_char_i = '0;
    logic [7:0] fill_attr_i = '0;
    logic       busy_o;
    logic [4:0] scroll_row_o;

    tile_attr_buffer dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
        .col_r_i(col_r_i), .row_r_i(row_r_i),
        .dout_char_o(dout_char_o), .dout_attr_o(dout_attr_o),
        .clear_i(clear_i), .scroll_i(scroll_i),
        .fill_char_i(fill_char_i), .fill_attr_i(fill_attr_i),
        .busy_o(busy_o), .scroll_row_o(scroll_row_o)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] rq[$];
    logic [14:0] dq[$];
    logic disp_v = 1'b0;
    logic d_vld = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk_i) d_vld <= disp_v;

    always @(negedge clk_i) begin
        if (bus.r_valid_o === 1'b1) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: r_valid_o with no read pending, data 0x%0h", bus.r_data_o);
            end else
                chk("rd_data", bus.r_data_o, rq.pop_front());
        end
        if (d_vld) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL disp_unexpected: no display expectation queued");
            end else
                chk("disp_tile", {17'b0, dout_attr_o, dout_char_o}, {17'b0, dq.pop_front()});
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
        bus.wr_en_i  = 1'b1;
        bus.w_addr_i = 12'(a);
        bus.din_i    = d;
        bus.w_strb_i = s;
        tick();
        bus.wr_en_i  = 1'b0;
    endtask

    task automatic rd(input int a, input logic [31:0] e);
        bus.r_req_i  = 1'b1;
        bus.r_addr_i = 12'(a);
        rq.push_back(e);
        tick();
        bus.r_req_i  = 1'b0;
    endtask

    task automatic disp(input int r, input int c, input logic [14:0] e);
        row_r_i = 5'(r);
        col_r_i = 7'(c);
        disp_v  = 1'b1;
        dq.push_back(e);
        tick();
        disp_v  = 1'b0;
    endtask

    task automatic cmd(input logic clr, input logic scr, input logic [6:0] fc, input logic [7:0] fa);
        clear_i     = clr;
        scroll_i    = scr;
        fill_char_i = fc;
        fill_attr_i = fa;
        tick();
        clear_i     = 1'b0;
        scroll_i    = 1'b0;
    endtask

    task automatic wait_busy(output int n, input int pulse_at);
        n = 0;
        while (busy_o && n < 5000) begin
            scroll_i = (n == pulse_at);
            tick();
            n++;
        end
        scroll_i = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.wr_en_i = 1'b0;
        bus.w_addr_i = '0;
        bus.w_strb_i = '0;
        bus.din_i = '0;
        bus.r_req_i = 1'b0;
        bus.r_addr_i = '0;
        tick();
        tick();
        chk("rst_wr_ready", 32'(bus.wr_ready_o), 1);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_scroll_row", 32'(scroll_row_o), 0);
        chk("rst_r_valid", 32'(bus.r_valid_o), 0);
        chk("rst_r_data", bus.r_data_o, 0);
        chk("rst_dout", {17'b0, dout_attr_o, dout_char_o}, 0);
        rst_i = 1'b0;
        tick();
        // full clear and sweep of every tile
        cmd(1'b1, 1'b0, 7'h20, 8'h0F);
        wait_busy(n, -1);
        chk("clear_busy_cycles", 32'(n), 2400);
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                disp(r, c, {8'h0F, 7'h20});
        disp(30, 0, 15'h0);
        disp(0, 80, 15'h0);
        // packed bus write/read
        wr(0, 32'h0F41_0742, 4'hF);
        rd(0, 32'h0F41_0742);
        disp(0, 0, {8'h07, 7'h42});
        disp(0, 1, {8'h0F, 7'h41});
        wr(2399, 32'h1234_0555, 4'hF);
        rd(2399, 32'h0000_0555);
        wr(10, 32'h3333_1166, 4'h3);
        rd(10, 32'h0F20_1166);
        wr(20, 32'h0000_ABC1, 4'hF);
        rd(20, 32'h0000_AB41);
        // one-row scroll
        wr(80, 32'h0000_0741, 4'h3);
        cmd(1'b0, 1'b1, 7'h20, 8'h1E);
        chk("scroll_row_1", 32'(scroll_row_o), 1);
        wait_busy(n, -1);
        chk("scroll_busy_cycles", 32'(n), 80);
        disp(0, 0, {8'h07, 7'h41});
        disp(28, 0, {8'h0F, 7'h20});
        for (int c = 0; c < 80; c++)
            disp(29, c, {8'h1E, 7'h20});
        rd(0, 32'h0F20_0741);
        rd(2399, 32'h0000_1E20);
        // write stalls while busy, then lands
        cmd(1'b1, 1'b0, 7'h2E, 8'h70);
        bus.wr_en_i = 1'b1;
        bus.w_addr_i = 12'd5;
        bus.din_i = 32'h0000_5A33;
        bus.w_strb_i = 4'h3;
        chk("busy_wr_ready", 32'(bus.wr_ready_o), 0);
        n = 0;
        while (!bus.wr_ready_o && n < 5000) begin
            tick();
            n++;
        end
        chk("stall_cycles", 32'(n), 2400);
        tick();
        bus.wr_en_i = 1'b0;
        disp(0, 5, {8'h5A, 7'h33});
        disp(0, 6, {8'h70, 7'h2E});
        // reset in the middle of a clear
        cmd(1'b1, 1'b0, 7'h11, 8'h22);
        repeat (100) tick();
        rst_i = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy_o), 0);
        chk("midrst_scroll_row", 32'(scroll_row_o), 0);
        chk("midrst_wr_ready", 32'(bus.wr_ready_o), 1);
        rst_i = 1'b0;
        tick();
        disp(0, 0, {8'h22, 7'h11});
        disp(29, 79, {8'h70, 7'h2E});
        // 30 back-to-back scrolls wrap the row pointer
        for (int i = 1; i <= 30; i++) begin
            cmd(1'b0, 1'b1, 7'h20, 8'h0F);
            chk("scroll_wrap_row", 32'(scroll_row_o), 32'(i % 30));
            wait_busy(n, -1);
            chk("scroll_wrap_busy", 32'(n), 80);
        end
        // clear wins over simultaneous scroll; scroll during busy ignored
        cmd(1'b0, 1'b1, 7'h20, 8'h0F);
        wait_busy(n, -1);
        chk("pre_clr_scroll_row", 32'(scroll_row_o), 1);
        cmd(1'b1, 1'b1, 7'h07, 8'h1F);
        wait_busy(n, 100);
        chk("clr_scr_busy_cycles", 32'(n), 2400);
        chk("clr_scr_scroll_row", 32'(scroll_row_o), 1);
        disp(0, 0, {8'h1F, 7'h07});
        disp(29, 79, {8'h1F, 7'h07});
        rd(0, 32'h1F07_1F07);
        repeat (3) tick();
        chk("rd_queue_drained", 32'(rq.size()), 0);
        chk("disp_queue_drained", 32'(dq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
